reg_wb_arbiter: RTL

Shares the register file's single write port between two writeback sources: source 0 is the ALU and source 1 is load/CSR. Each source has a one-entry holding slot with a valid/ready handshake. Slots are arbitrated each cycle, and the winner is driven through a registered write stage onto the register file write port (wreg/wdata/we). Writes to x0 are absorbed without consuming a port cycle.

---
 rtl/reg_wb_pkg.sv | 17 +
 rtl/wb_slot.sv | 57 +++++
 rtl/reg_wb_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
package reg_wb_pkg;

  localparam int RegAddrWidth = 5;
  localparam int SrcNum       = 2;

  typedef struct packed {
    logic [RegAddrWidth-1:0] rd;
    logic [31:0]             data;
  } wb_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot. Flush beats load, load beats release,
// so a slot can be refilled in the cycle it empties.
module wb_slot
  import reg_wb_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [RegAddrWidth-1:0] rd_i,
  input  logic [DataWidth-1:0]    data_i,
  input  logic                    load_i,
  input  logic                    release_i,
  output logic                    valid_o,
  output logic [RegAddrWidth-1:0] rd_o,
  output logic [DataWidth-1:0]    data_o
);

  slot_state_t             state_q, state_d;
  logic [RegAddrWidth-1:0] rd_q;
  logic [DataWidth-1:0]    data_q;
  logic                    accept;

  assign accept = valid_i && load_i && !flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = SLOT_EMPTY;
    end else if (accept) begin
      state_d = SLOT_FULL;
    end else if (release_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= SLOT_EMPTY;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q   <= rd_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-source writeback arbiter onto the single register-file write port.
// REG_WB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise source 1 always wins.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_valid_0,
  output logic                    o_ready_0,
  input  logic [RegAddrWidth-1:0] i_rd_0,
  input  logic [DataWidth-1:0]    i_data_0,
  input  logic                    i_valid_1,
  output logic                    o_ready_1,
  input  logic [RegAddrWidth-1:0] i_rd_1,
  input  logic [DataWidth-1:0]    i_data_1,
  output logic [RegAddrWidth-1:0] o_wreg,
  output logic [DataWidth-1:0]    o_wdata,
  output logic                    o_we,
  output logic                    o_idle
);

  logic [SrcNum-1:0]       slot_v, elig, retire, grant, ready, rel;
  logic [RegAddrWidth-1:0] slot_rd_0, slot_rd_1;
  logic [DataWidth-1:0]    slot_data_0, slot_data_1;
  logic                    win1;

  logic                    we_q, we_d;
  logic [RegAddrWidth-1:0] wreg_q, wreg_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;

  wb_slot #(.DataWidth(DataWidth)) u_slot_0 (
    .clk_i(i_clk), .rst_i(i_rst), .flush_i(i_flush),
    .valid_i(i_valid_0), .rd_i(i_rd_0), .data_i(i_data_0),
    .load_i(ready[0]), .release_i(rel[0]),
    .valid_o(slot_v[0]), .rd_o(slot_rd_0), .data_o(slot_data_0)
  );

  wb_slot #(.DataWidth(DataWidth)) u_slot_1 (
    .clk_i(i_clk), .rst_i(i_rst), .flush_i(i_flush),
    .valid_i(i_valid_1), .rd_i(i_rd_1), .data_i(i_data_1),
    .load_i(ready[1]), .release_i(rel[1]),
    .valid_o(slot_v[1]), .rd_o(slot_rd_1), .data_o(slot_data_1)
  );

`ifdef REG_WB_ARB_ROUND_ROBIN_EN
  // ptr_q names the source that wins the next two-way conflict.
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (!i_flush && (&elig)) begin
      ptr_d = ~win1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign win1 = ptr_q;
`else
  assign win1 = 1'b1;
`endif

  // Ready depends only on slot state and the pointer, never on i_valid/i_rd.
  always_comb begin
    elig[0]   = slot_v[0] && (slot_rd_0 != '0);
    elig[1]   = slot_v[1] && (slot_rd_1 != '0);
    retire[0] = slot_v[0] && (slot_rd_0 == '0);
    retire[1] = slot_v[1] && (slot_rd_1 == '0);
    grant[0]  = elig[0] && !(elig[1] && win1);
    grant[1]  = elig[1] && !(elig[0] && !win1);
    rel       = grant | retire;
    ready     = {SrcNum{!i_flush}} & (~slot_v | rel);
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (!i_flush) begin
      if (grant[0]) begin
        we_d    = 1'b1;
        wreg_d  = slot_rd_0;
        wdata_d = slot_data_0;
      end else if (grant[1]) begin
        we_d    = 1'b1;
        wreg_d  = slot_rd_1;
        wdata_d = slot_data_1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_ready_0 = ready[0];
  assign o_ready_1 = ready[1];
  assign o_we      = we_q;
  assign o_wreg    = wreg_q;
  assign o_wdata   = wdata_q;
  assign o_idle    = !slot_v[0] && !slot_v[1] && !we_q;

endmodule
